// File: rtl/sticky_shift_sequencer.sv
// Multi-cycle right shifter with sticky accumulation, up to STEP positions per clock.
// Optional ZERO_SKIP_EN: finish early once the working register has shifted to all zeros.
module sticky_shift_sequencer #(
  parameter int unsigned N    = 8,
  parameter int unsigned es   = 4,
  parameter int unsigned L    = 1,
  parameter int unsigned STEP = 2,
  localparam int unsigned W   = N - es + 3,
  localparam int unsigned T   = W + L
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] A,
  input  logic [N-1:0] shift,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] Z
);

  localparam int unsigned RW = $clog2(T + 1);

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e        state_q;
  logic [T-1:0]  t_q;
  logic [RW-1:0] rem_q;
  logic          acc_q;
  logic [W-1:0]  z_q;
  logic          out_valid_q;
  logic          in_ready_q;

  logic [T-1:0]  load_t;
  logic [RW-1:0] load_rem;
  logic [RW-1:0] s;
  logic [T-1:0]  lost_mask;
  logic [T-1:0]  t_step;
  logic [RW-1:0] rem_step;
  logic          acc_step;

  // Data bits above the guard field, with everything at or below the guard folded into Z[0].
  function automatic logic [W-1:0] z_of(input logic [T-1:0] t, input logic acc);
    return {t[T-1:L+1], acc | (|t[L:0])};
  endfunction

  always_comb begin
    load_t = T'(A) << L;
    if (32'(shift) >= T) begin
      load_rem = RW'(T);
    end else begin
      load_rem = RW'(shift);
    end
    if (32'(rem_q) < STEP) begin
      s = rem_q;
    end else begin
      s = RW'(STEP);
    end
    lost_mask = ~({T{1'b1}} << s);
    t_step    = t_q >> s;
    rem_step  = rem_q - s;
    acc_step  = acc_q | (|(t_q & lost_mask));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      t_q         <= '0;
      rem_q       <= '0;
      acc_q       <= 1'b0;
      z_q         <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            t_q        <= load_t;
            rem_q      <= load_rem;
            acc_q      <= 1'b0;
            in_ready_q <= 1'b0;
            if (load_rem == '0) begin
              state_q     <= StDone;
              z_q         <= z_of(load_t, 1'b0);
              out_valid_q <= 1'b1;
            end else begin
              state_q <= StShift;
            end
          end
        end
        StShift: begin
`ifdef ZERO_SKIP_EN
          if (t_q == '0) begin
            state_q     <= StDone;
            z_q         <= z_of(t_q, acc_q);
            out_valid_q <= 1'b1;
          end else
`endif
          begin
            t_q   <= t_step;
            rem_q <= rem_step;
            acc_q <= acc_step;
            if (rem_step == '0) begin
              state_q     <= StDone;
              z_q         <= z_of(t_step, acc_step);
              out_valid_q <= 1'b1;
            end
          end
        end
        StDone: begin
          // Returning to idle never accepts; the next request lands on a later edge.
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign Z         = z_q;

endmodule

// File: tb/tb_sticky_shift_sequencer.sv
// Self-checking bench for sticky_shift_sequencer against an arithmetic reference model.
// Honours ZERO_SKIP_EN in the latency model when the same define is given to the bench.
module tb_sticky_shift_sequencer;

  localparam int unsigned N    = 8;
  localparam int unsigned ES   = 4;
  localparam int unsigned L    = 1;
  localparam int unsigned STEP = 2;
  localparam int unsigned W    = N - ES + 3;
  localparam int unsigned T    = W + L;
`ifdef ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_drv;
  logic [N-1:0] shift_drv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] z;

  int checks = 0;
  int errors = 0;

  sticky_shift_sequencer #(.N(N), .es(ES), .L(L), .STEP(STEP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .A        (a_drv),
    .shift    (shift_drv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .Z        (z)
  );

  always #5 clk = ~clk;

  // Sticky = any bit of {A, guard} that falls below the kept data field.
  function automatic logic [W-1:0] model_z(input logic [W-1:0] a, input int unsigned sh);
    longint unsigned t, mask;
    int unsigned s, cut;
    s    = (sh > T) ? T : sh;
    t    = 64'(a) << L;
    cut  = s + L + 1;
    mask = (64'd1 << cut) - 64'd1;
    return W'((t >> cut) << 1) | W'((t & mask) != 0);
  endfunction

  function automatic int model_lat(input logic [W-1:0] a, input int unsigned sh);
    int unsigned s, n, k, bl;
    longint unsigned t;
    s  = (sh > T) ? T : sh;
    n  = (s + STEP - 1) / STEP;
    t  = 64'(a) << L;
    bl = 0;
    for (int i = 0; i < 64; i++) if (t[i]) bl = i + 1;
    if (SKIP && bl <= s) begin
      k = (bl + STEP - 1) / STEP;
      if (k < n) return int'(k) + 2;
    end
    return int'(n) + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and waits for the result; lat counts the accepting edge as edge 1.
  task automatic do_txn(input logic [W-1:0] a, input logic [N-1:0] sh,
                        output int lat, output logic [W-1:0] zr);
    int guard;
    guard = 0;
    while (!in_ready && guard < 100) begin
      tick();
      guard++;
    end
    in_valid  = 1'b1;
    a_drv     = a;
    shift_drv = sh;
    tick();
    in_valid  = 1'b0;
    a_drv     = W'($urandom);
    shift_drv = N'($urandom);
    lat = 1;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) lat = -1;
    zr = z;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || z !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: out_valid=%b Z=%b in_ready=%b, required 0 0000000 1",
               out_valid, z, in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] av [4];
    logic [N-1:0] sv [4];
    logic [W-1:0] ez [4];
    int           el [4];
    logic [W-1:0] zr;
    int           lat;
    av = '{7'b0110101, 7'b0101010, 7'b1000000, 7'b0000001};
    sv = '{8'd3, 8'd0, 8'd200, 8'd8};
    ez = '{7'b0000111, 7'b0101010, 7'b0000001, 7'b0000001};
    el = '{3, 1, 5, SKIP ? 3 : 5};
    for (int i = 0; i < 4; i++) begin
      do_txn(av[i], sv[i], lat, zr);
      checks++;
      if (zr !== ez[i]) begin
        errors++;
        $display("FAIL directed_z[%0d]: Z=%b, required %b", i, zr, ez[i]);
      end
      checks++;
      if (lat !== el[i]) begin
        errors++;
        $display("FAIL directed_lat[%0d]: latency=%0d, required %0d", i, lat, el[i]);
      end
      drain();
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, zr;
    logic [N-1:0] sh;
    int           lat, stall;
    for (int i = 0; i < 60; i++) begin
      a  = ($urandom_range(0, 2) == 0) ? W'($urandom_range(0, 3)) : W'($urandom);
      sh = ($urandom_range(0, 3) == 0) ? N'($urandom) : N'($urandom_range(0, T + 1));
      do_txn(a, sh, lat, zr);
      checks++;
      if (zr !== model_z(a, sh)) begin
        errors++;
        $display("FAIL random_z: A=%b shift=%0d Z=%b, required %b", a, sh, zr, model_z(a, sh));
      end
      checks++;
      if (lat !== model_lat(a, sh)) begin
        errors++;
        $display("FAIL random_lat: A=%b shift=%0d latency=%0d, required %0d",
                 a, sh, lat, model_lat(a, sh));
      end
      stall = $urandom_range(0, 2);
      for (int c = 0; c < stall; c++) begin
        tick();
        checks++;
        if (out_valid !== 1'b1 || z !== model_z(a, sh)) begin
          errors++;
          $display("FAIL random_hold: out_valid=%b Z=%b, required 1 %b",
                   out_valid, z, model_z(a, sh));
        end
      end
      drain();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++;
        $display("FAIL random_release: out_valid=%b in_ready=%b, required 0 1",
                 out_valid, in_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] zr;
    int           lat;
    do_txn(7'b1011011, 8'd5, lat, zr);
    checks++;
    if (zr !== model_z(7'b1011011, 5)) begin
      errors++;
      $display("FAIL bp_z: Z=%b, required %b", zr, model_z(7'b1011011, 5));
    end
    // A competing request during the stall must be ignored.
    in_valid  = 1'b1;
    a_drv     = 7'b1111111;
    shift_drv = 8'd0;
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || z !== model_z(7'b1011011, 5) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall[%0d]: out_valid=%b Z=%b in_ready=%b, required 1 %b 0",
                 c, out_valid, z, in_ready, model_z(7'b1011011, 5));
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ez;
    int           lat, last, n;
    ez   = model_z(7'b0110101, 3);
    lat  = model_lat(7'b0110101, 3);
    last = -1;
    n    = 0;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a_drv     = 7'b0110101;
    shift_drv = 8'd3;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid) begin
        checks++;
        if (z !== ez) begin
          errors++;
          $display("FAIL b2b_z: cycle %0d Z=%b, required %b", c, z, ez);
        end
        if (last >= 0) begin
          checks++;
          if (c - last != lat + 1) begin
            errors++;
            $display("FAIL b2b_period: gap=%0d, required %0d", c - last, lat + 1);
          end
        end
        last = c;
        n++;
      end
    end
    checks++;
    if (n != (20 - lat) / (lat + 1) + 1) begin
      errors++;
      $display("FAIL b2b_count: results=%0d, required %0d", n, (20 - lat) / (lat + 1) + 1);
    end
    in_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    int seen;
    in_valid  = 1'b1;
    a_drv     = 7'b0110101;
    shift_drv = 8'd8;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || z !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_reset: out_valid=%b Z=%b in_ready=%b, required 0 0000000 1",
               out_valid, z, in_ready);
    end
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_output: out_valid cycles=%0d, required 0", seen);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_drv     = '0;
    shift_drv = '0;
    out_ready = 1'b0;
    #1;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
